// File: rtl/div_samp.sv
// Sequential restoring divider: WIDTH_N-bit dividend by WIDTH_D-bit divisor,
// one quotient bit per clock under a start/busy/done handshake.
module div_samp #(
    parameter int unsigned WIDTH_N = 8,
    parameter int unsigned WIDTH_D = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_N-1:0] A_in,
    input  logic [WIDTH_D-1:0] B_in,
    output logic [WIDTH_N-1:0] Quo,
    output logic [WIDTH_D-1:0] Rem,
    output logic               div_zero,
    output logic               busy,
    output logic               done
);
    localparam int unsigned RW = WIDTH_D + 1;
    localparam int unsigned CW = $clog2(WIDTH_N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH_N-1:0] dvd_q, dvd_d;
    logic [WIDTH_D-1:0] dvs_q, dvs_d;
    logic [WIDTH_D-1:0] prem_q, prem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH_N-1:0] quo_q, quo_d;
    logic [WIDTH_D-1:0] rem_q, rem_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [RW-1:0]      shifted;
    logic [WIDTH_D-1:0] diff;
    logic               qbit;
    logic [WIDTH_D-1:0] prem_next;

    // Partial remainder stays below the divisor, so WIDTH_D bits hold it between steps;
    // the shifted trial value needs one extra bit.
    always_comb begin
        shifted   = {prem_q, dvd_q[WIDTH_N-1]};
        qbit      = (shifted >= {1'b0, dvs_q});
        diff      = WIDTH_D'(shifted - {1'b0, dvs_q});
        prem_next = qbit ? diff : shifted[WIDTH_D-1:0];

        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d  = A_in;
                    dvs_d  = B_in;
                    busy_d = 1'b1;
                    if (B_in == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = A_in[WIDTH_D-1:0];
                        dz_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                        prem_d  = '0;
                        cnt_d   = CW'(WIDTH_N);
                    end
                end
            end
            CALC: begin
                prem_d = prem_next;
                dvd_d  = {dvd_q[WIDTH_N-2:0], qbit};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quo_d   = {dvd_q[WIDTH_N-2:0], qbit};
                    rem_d   = prem_next;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Quo      = quo_q;
    assign Rem      = rem_q;
    assign div_zero = dz_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_div_samp.sv
// Bench for div_samp: arithmetic reference model checked every cycle, plus
// directed operations with hand-computed results and latencies.
module tb_div_samp;
    localparam int unsigned WN = 8;
    localparam int unsigned WD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [WN-1:0] A_in;
    logic [WD-1:0] B_in;
    logic [WN-1:0] Quo;
    logic [WD-1:0] Rem;
    logic          div_zero, busy, done;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit mon_en    = 1'b0;

    div_samp #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A_in(A_in), .B_in(B_in),
        .Quo(Quo), .Rem(Rem), .div_zero(div_zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: busy cycles left after each edge, results from plain division.
    int            m_left;
    logic [WN-1:0] m_a;
    logic [WD-1:0] m_b;
    logic [WN-1:0] e_quo;
    logic [WD-1:0] e_rem;
    logic          e_dz;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            e_quo  = '0;
            e_rem  = '0;
            e_dz   = 1'b0;
        end else begin
            if (m_left == 0) begin
                if (start) begin
                    m_a    = A_in;
                    m_b    = B_in;
                    m_left = (B_in == 0) ? 1 : int'(WN) + 1;
                end
            end else begin
                m_left--;
            end
            if (m_left == 1) begin
                if (m_b == 0) begin
                    e_quo = '1;
                    e_rem = m_a[WD-1:0];
                    e_dz  = 1'b1;
                end else begin
                    e_quo = WN'(m_a / m_b);
                    e_rem = WD'(m_a % m_b);
                    e_dz  = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_done", int'(done), int'(m_left == 1));
            chk("mon_busy", int'(busy), int'(m_left > 0));
            chk("mon_quo", int'(Quo), int'(e_quo));
            chk("mon_rem", int'(Rem), int'(e_rem));
            chk("mon_dz", int'(div_zero), int'(e_dz));
        end
    end

    task automatic run_op(input int a, input int b, input int eq, input int er,
                          input int ez, input int elat);
        int lat;
        @(negedge clk);
        start = 1'b1;
        A_in  = WN'(a);
        B_in  = WD'(b);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("op_latency", lat, elat);
        chk("op_quo", int'(Quo), eq);
        chk("op_rem", int'(Rem), er);
        chk("op_dz", int'(div_zero), ez);
        @(negedge clk);
        chk("op_done_width", int'(done), 0);
        chk("op_busy_end", int'(busy), 0);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        A_in  = '0;
        B_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_quo", int'(Quo), 0);
        chk("rst_rem", int'(Rem), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_op(200, 13, 15, 5, 0, 9);
        run_op(255, 1, 255, 0, 0, 9);
        run_op(7, 9, 0, 7, 0, 9);
        run_op(0, 15, 0, 0, 0, 9);
        run_op(100, 0, 255, 4, 1, 1);
        run_op(100, 10, 10, 0, 0, 9);

        // A second start mid-calculation must be dropped.
        @(negedge clk);
        start = 1'b1; A_in = 8'd200; B_in = 4'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; A_in = 8'd50; B_in = 4'd5;
        @(negedge clk);
        start = 1'b0;
        count_done(20, n);
        chk("ign_done_count", n, 1);
        chk("ign_quo", int'(Quo), 15);
        chk("ign_rem", int'(Rem), 5);

        // Reset in the middle of 200/13 aborts it with no done pulse.
        @(negedge clk);
        start = 1'b1; A_in = 8'd200; B_in = 4'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_quo", int'(Quo), 0);
        chk("abort_rem", int'(Rem), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_done(12, n);
        chk("abort_no_done", n, 0);
        run_op(81, 9, 9, 0, 0, 9);

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) run_op(a, b, 255, a % 16, 1, 1);
                else        run_op(a, b, a / b, a % b, 0, 9);
            end
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
